// File: rtl/serial_mag_comparator.sv
// serial_mag_comparator: MSB-first bit-serial unsigned compare with early exit and valid/ready handshakes
module serial_mag_comparator #(
  parameter int WIDTH = 8
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [WIDTH-1:0]               a,
  input  logic [WIDTH-1:0]               b,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic                           aeb,
  output logic                           agb,
  output logic                           alb,
  output logic [$clog2(WIDTH+1)-1:0]     cmp_cycles
);
  localparam int CW = $clog2(WIDTH+1);
  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
  state_t           state_q, state_d;
  logic [WIDTH-1:0] sa_q, sa_d, sb_q, sb_d;
  logic [CW-1:0]    cnt_q, cnt_d, cmp_q, cmp_d;
  logic             aeb_q, aeb_d, agb_q, agb_d, alb_q, alb_d;
  logic             ma, mb;
  assign ma = sa_q[WIDTH-1];
  assign mb = sb_q[WIDTH-1];
  always_comb begin
    state_d = state_q;
    sa_d = sa_q;
    sb_d = sb_q;
    cnt_d = cnt_q;
    cmp_d = cmp_q;
    aeb_d = aeb_q;
    agb_d = agb_q;
    alb_d = alb_q;
    case (state_q)
      IDLE: if (in_valid) begin
        state_d = SCAN;
        sa_d = a;
        sb_d = b;
        cnt_d = '0;
      end
      SCAN: begin
        cnt_d = cnt_q + CW'(1);
        if (ma != mb) begin
          agb_d = ma & ~mb;
          alb_d = ~ma & mb;
          aeb_d = 1'b0;
          cmp_d = cnt_q + CW'(1);
          state_d = DONE;
        end else if (cnt_q == CW'(WIDTH - 1)) begin
          aeb_d = 1'b1;
          agb_d = 1'b0;
          alb_d = 1'b0;
          cmp_d = CW'(WIDTH);
          state_d = DONE;
        end else begin
          sa_d = sa_q << 1;
          sb_d = sb_q << 1;
        end
      end
      DONE: if (out_ready) begin
        aeb_d = 1'b0;
        agb_d = 1'b0;
        alb_d = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sa_q <= '0;
      sb_q <= '0;
      cnt_q <= '0;
      cmp_q <= '0;
      aeb_q <= 1'b0;
      agb_q <= 1'b0;
      alb_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sa_q <= sa_d;
      sb_q <= sb_d;
      cnt_q <= cnt_d;
      cmp_q <= cmp_d;
      aeb_q <= aeb_d;
      agb_q <= agb_d;
      alb_q <= alb_d;
    end
  end
  assign in_ready = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign aeb = aeb_q;
  assign agb = agb_q;
  assign alb = alb_q;
  assign cmp_cycles = cmp_q;
endmodule

// File: tb/tb_serial_mag_comparator.sv
// tb_serial_mag_comparator: directed vectors plus a transaction-level model checked every cycle
module tb_serial_mag_comparator;
  localparam int W = 8;
  logic clk = 1'b0, rst_n, in_valid, in_ready, out_valid, out_ready, aeb, agb, alb;
  logic [W-1:0] a, b;
  logic [3:0] cmp_cycles;
  int nchk = 0, nerr = 0;

  serial_mag_comparator #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready), .aeb(aeb), .agb(agb), .alb(alb),
    .cmp_cycles(cmp_cycles)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    nchk++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // k = position of the first differing bit counted from the MSB, or W when equal
  function automatic int kfor(input logic [W-1:0] x, input logic [W-1:0] y);
    logic [W-1:0] d = x ^ y;
    for (int i = W - 1; i >= 0; i--) if (d[i]) return W - i;
    return W;
  endfunction

  int m_rem;
  logic m_done;
  logic [2:0] m_flags, m_pf;
  logic [3:0] m_cyc, m_pc;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_rem <= 0;
      m_done <= 1'b0;
      m_flags <= 3'b000;
      m_cyc <= 4'd0;
      m_pf <= 3'b000;
      m_pc <= 4'd0;
    end else if (m_done) begin
      if (out_ready) begin
        m_done <= 1'b0;
        m_flags <= 3'b000;
      end
    end else if (m_rem > 0) begin
      m_rem <= m_rem - 1;
      if (m_rem == 1) begin
        m_done <= 1'b1;
        m_flags <= m_pf;
        m_cyc <= m_pc;
      end
    end else if (in_valid) begin
      m_rem <= kfor(a, b);
      m_pc <= 4'(kfor(a, b));
      m_pf <= {a == b, a > b, a < b};
    end
  end

  always @(negedge clk)
    chk("cycle", int'({in_ready, out_valid, aeb, agb, alb, cmp_cycles}),
        int'({!m_done && m_rem == 0, m_done, m_flags, m_cyc}));

  task automatic start(input logic [W-1:0] ta, input logic [W-1:0] tb_);
    int n = 0;
    while (!in_ready && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    in_valid = 1'b1;
    a = ta;
    b = tb_;
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = ~ta;
    b = ta;
  endtask

  task automatic wait_done(input string nm, input logic [2:0] ef, input int ec);
    int lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({nm, "_lat"}, lat, ec);
    chk({nm, "_flags"}, int'({aeb, agb, alb}), int'(ef));
    chk({nm, "_cyc"}, int'(cmp_cycles), ec);
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic txn(input string nm, input logic [W-1:0] ta, input logic [W-1:0] tb_,
                     input logic [2:0] ef, input int ec);
    start(ta, tb_);
    wait_done(nm, ef, ec);
    release_out();
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    a = '0;
    b = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("rst_ready", int'(in_ready), 1);
    txn("msb", 8'h80, 8'h7F, 3'b010, 1);
    txn("lsb", 8'h12, 8'h13, 3'b001, 8);
    txn("zero", 8'h00, 8'h00, 3'b100, 8);
    // mid-traffic reset while a result waits in DONE
    start(8'h55, 8'h54);
    wait_done("pre_rst", 3'b010, 8);
    rst_n = 1'b0;
    #1;
    chk("rst_async", int'({in_ready, out_valid, aeb, agb, alb, cmp_cycles}), 9'b1_0_000_0000);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    txn("post_rst", 8'h80, 8'h7F, 3'b010, 1);
    // backpressure with a new operand pair waiting on in_valid
    start(8'h40, 8'h20);
    wait_done("bp", 3'b010, 2);
    in_valid = 1'b1;
    a = 8'h03;
    b = 8'h05;
    repeat (5) begin
      @(posedge clk); #1;
      chk("bp_hold", int'({out_valid, agb, cmp_cycles}), 6'b1_1_0010);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("bp_noacc", int'({in_ready, out_valid}), 2'b10);
    @(posedge clk); #1;
    chk("bp_acc", int'(in_ready), 0);
    in_valid = 1'b0;
    wait_done("bp_next", 3'b001, 6);
    release_out();
    // abort on the 4th SCAN cycle
    start(8'h01, 8'h00);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      chk("abort_ov", int'(out_valid), 0);
    end
    rst_n = 1'b1;
    txn("ff", 8'hFF, 8'hFF, 3'b100, 8);
    // random traffic checked by the model every cycle
    for (int i = 0; i < 600; i++) begin
      @(posedge clk); #1;
      in_valid = 1'($urandom_range(0, 1));
      a = 8'($urandom);
      case ($urandom_range(0, 3))
        0: b = a;
        1: b = a ^ (8'h01 << $urandom_range(0, 7));
        default: b = 8'($urandom);
      endcase
      out_ready = 1'($urandom_range(0, 1));
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    chk("drain_idle", int'({in_ready, out_valid}), 2'b10);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule

// File: doc/serial_mag_comparator.md
# serial_mag_comparator

Multi-cycle magnitude comparator that accepts two WIDTH-bit unsigned operands over a valid/ready handshake. It scans them MSB-first, one bit pair per cycle, and returns a registered one-hot equal/greater/less result over a second valid/ready handshake. It terminates early at the first differing bit. It sits in the comparison datapath, feeding the single-bit comparator stage's consumers with full-word results from area-constrained, bit-serial logic.

## Interface
- WIDTH, 8, operand width in bits; legal range 2..32.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset; asserts immediately, deasserts synchronously to clk.
- in_valid  input  1  operand pair a/b is valid.
- in_ready  output  1  block can accept operands; high only in IDLE.
- a  input  WIDTH  unsigned operand A; sampled only on in_valid & in_ready.
- b  input  WIDTH  unsigned operand B; sampled only on in_valid & in_ready.
- out_valid  output  1  result fields are valid; high only in DONE.
- out_ready  input  1  consumer accepts the result.
- aeb  output  1  A == B.
- agb  output  1  A > B.
- alb  output  1  A < B.
- cmp_cycles  output  clog2(WIDTH+1)  number of bit pairs examined to produce the result (1..WIDTH).

## Operation
- States:
  - IDLE: in_ready=1; out_valid=0.
  - SCAN: in_ready=0; out_valid=0.
  - DONE: in_ready=0; out_valid=1.
- Transitions:
  - IDLE -> SCAN on in_valid & in_ready. Load a/b into internal shift registers sa/sb and clear the bit counter.
  - SCAN, each cycle: compare sa[WIDTH-1] with sb[WIDTH-1], and increment the counter.
    - Bits differ: register agb = sa[MSB] & ~sb[MSB] and alb = ~sa[MSB] & sb[MSB]; set aeb=0; load cmp_cycles = counter+1; go to DONE.
    - Bits equal and this is the WIDTH-th pair: register aeb=1, agb=0, alb=0, cmp_cycles=WIDTH; go to DONE.
    - Bits equal otherwise: shift sa and sb left by 1; stay in SCAN.
  - DONE -> IDLE on out_ready. aeb/agb/alb are cleared to 0 on that edge; cmp_cycles holds its last value.
- Result fields are exactly one-hot whenever out_valid=1, and all zero in IDLE and SCAN.
- Comparison is unsigned. No sign handling.
- Changes on a/b after acceptance have no effect on the scan in progress.

## Timing
- Reset values (while rst_n=0 and after): state IDLE, in_ready=1, out_valid=0, aeb=agb=alb=0, cmp_cycles=0, internal registers 0.
- Latency: let k = 1 + (WIDTH-1 − index of the highest differing bit), or k = WIDTH if A == B.
  - SCAN occupies k cycles after the accept edge.
  - out_valid rises after the k-th clock edge following the accept edge.
  - Minimum latency: 1 cycle (MSBs differ). Maximum: WIDTH cycles (equal operands, or difference only in the LSB).
- Throughput: one operation per k+2 cycles at best; no new operand is accepted in DONE even if out_ready is high that cycle. The next accept occurs in the following IDLE cycle.
- Backpressure: while out_valid=1 and out_ready=0, aeb/agb/alb/cmp_cycles and out_valid stay stable indefinitely.
- out_ready while not in DONE is ignored. in_valid outside IDLE is ignored (the producer must hold its data until in_ready).
- Reset mid-SCAN or mid-DONE: the operation is aborted, no out_valid pulse is produced, and all outputs return to their reset values asynchronously.
- in_ready and out_valid are decoded directly from the state register (no combinational path from in_valid/out_ready).

## Test plan
- Reset: hold rst_n=0 for 3 cycles mid-traffic -> out_valid=0, aeb=agb=alb=0, cmp_cycles=0, in_ready=1; release -> first accept works normally.
- MSB difference (WIDTH=8): a=0x80, b=0x7F -> agb=1, aeb=0, alb=0, cmp_cycles=1, out_valid rises 1 edge after accept.
- LSB difference: a=0x12, b=0x13 -> alb=1, cmp_cycles=8, out_valid rises 8 edges after accept. Also a=0x00, b=0x00 -> aeb=1, cmp_cycles=8.
- Backpressure: a=0x40, b=0x20, out_ready=0 for 5 cycles -> agb=1 and cmp_cycles=2 held stable with out_valid=1 throughout. in_valid held high with new operands is not accepted until one cycle after out_ready=1.
- Abort: accept a=0x01, b=0x00, then assert rst_n=0 on the 4th SCAN cycle -> no out_valid. After release, a=0xFF, b=0xFF -> aeb=1, cmp_cycles=8.
- Random: 10k random pairs with random in_valid/out_ready gaps, WIDTH=8 and WIDTH=32 -> result one-hot and matching the golden unsigned compare; cmp_cycles equals the golden first-difference position.
